lcd_read: RTL and testbench
===========================

Name: lcd_read

Overview:
- Read-side companion to the LCD write engine. Performs one HD44780-style 4-bit read transaction on the shared SF_D[11:8] bus: a status read (RS=0, busy flag plus address counter) or a data read (RS=1, DD/CG RAM byte).
- Returns the assembled byte to the controller FSM. The controller uses it to poll the busy flag instead of relying on fixed ~1.6 ms waits, and to read display RAM back.
- Sits beside the write engine. The top level muxes LCD_E/LCD_RS/LCD_RW and the SF_D output enable by which engine is busy.

Parameters:
- T_AS, 3: cycles RS/RW held stable before the first E rise (≥40 ns at 50 MHz).
- T_EH, 15: cycles E is high per nibble (≥230 ns).
- T_SAMPLE, 10: cycle within E-high at which SF_D is captured; must be <T_EH (≥160 ns tDDR).
- T_EL, 25: cycles E is low between the two nibbles.
- T_AH, 2: cycles RW stays high after the second E fall.
- MAX_POLL, 255: status-read retry limit; used only with LCD_POLL_BF_EN.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- start  in  1  request a read; accepted only when busy=0
- rs  in  1  register select for the request: 0=status, 1=data
- sf_d_in  in  4  SF_D[11:8] input from the pad
- sf_d_oe  out  1  FPGA drive enable for SF_D; 0 = released to the LCD
- LCD_E  out  1  enable strobe
- LCD_RS  out  1  register select to the LCD
- LCD_RW  out  1  1 = read
- q  out  8  assembled byte {high nibble, low nibble}
- busy  out  1  high while a transaction is in progress
- done  out  1  one-clock pulse; q is valid in the same cycle
- timeout  out  1  one-clock pulse, only with LCD_POLL_BF_EN

Behaviour:
- Reset values, applied on the next clk edge when reset=1, from any state: state=IDLE, LCD_E=0, LCD_RW=0, LCD_RS=0, sf_d_oe=1, busy=0, done=0, timeout=0, q=8'h00, counter=0.
- Reset mid-transaction aborts immediately. No partial q update. LCD_RW and sf_d_oe return to write-safe values in the same edge.
- Counter: one 8-bit counter, cleared on every state entry.
- Parameter check: T_SAMPLE ≥ T_EH is illegal; simulation $error at time 0.
- Bus ownership:
  - sf_d_oe goes 0 in the same edge LCD_RW goes 1.
  - On exit, LCD_RW falls first; sf_d_oe returns to 1 one cycle later (turnaround cycle).
- IDLE:
  - busy=0, LCD_RW=0.
  - On start=1, latch rs into LCD_RS, set LCD_RW=1, sf_d_oe=0, busy=1, go to SETUP.
  - start while busy=1 is ignored, with no queueing.
- SETUP: T_AS cycles, then LCD_E<=1 and go to EH1.
- EH1:
  - At counter==T_SAMPLE, q[7:4]<=sf_d_in.
  - After T_EH cycles, LCD_E<=0 and go to EL1.
- EL1: T_EL cycles, then LCD_E<=1 and go to EH2.
- EH2:
  - At counter==T_SAMPLE, q[3:0]<=sf_d_in.
  - After T_EH cycles, LCD_E<=0 and go to HOLD.
- HOLD:
  - T_AH cycles, then LCD_RW<=0, done<=1, busy<=0, go to TURN.
- TURN: one cycle, sf_d_oe<=1, go to IDLE.
  - start is ignored in TURN; busy was already 0, but the request is not latched.
  - The controller must wait for done before reissuing start. A start pulse landing in TURN is lost.
- Latency: done asserts exactly T_AS+2*T_EH+T_EL+T_AH = 60 cycles after the edge that samples start (defaults).
- q holds its value until the next capture or reset.
- Back-to-back reads: earliest next accept is 2 cycles after done.

Optional Feature:
- LCD_POLL_BF_EN defined:
  - In HOLD exit with LCD_RS=0 and q[7]=1, the block does not assert done. It re-enters SETUP (RW stays 1, busy stays 1) and increments the 8-bit poll count.
  - done fires only when BF=0.
  - If the poll count reaches MAX_POLL with BF still 1: assert timeout (one clock) instead of done, busy=0, go to TURN.
  - The poll count clears on accept.
  - Data reads (rs=1) are never repeated.
- LCD_POLL_BF_EN undefined: the timeout port is tied 0 and every transaction is a single read.

Test Plan:
- Status read: start with rs=0; bus model drives 4'h8 during E1 and 4'h5 during E2 → q=8'h85, done exactly 60 cycles after start; LCD_RS=0 and LCD_RW=1 throughout; sf_d_oe=0 from accept to done+1.
- Data read: rs=1; model drives 4'h4/4'h1 → q=8'h41, LCD_RS=1 for the whole transaction.
- Timing: measure E high = 15 cycles, E low = 25 cycles, RS/RW setup 3 cycles before the first E rise, RW falls 2 cycles after the last E fall. The model drives X except within the valid window after E rise + 8 cycles; check q holds no X.
- start asserted during EL1, and again during TURN → ignored; exactly one done; q unchanged by the extra start.
- reset asserted during EH2 → next edge: LCD_E=0, LCD_RW=0, sf_d_oe=1, busy=0, q=8'h00, no done.
- With LCD_POLL_BF_EN and MAX_POLL=4:
  - Model returns 8'h80 three times, then 8'h07 → single done with q=8'h07 after 4×60 cycles.
  - Model stuck at 8'h80 → timeout pulse, no done.

Source files
------------

// File: rtl/lcd_read.sv
// lcd_read: HD44780-style 4-bit read engine for the shared SF_D[11:8] bus.
// Performs one status read (rs=0: busy flag + address counter) or data read (rs=1: DD/CG RAM byte).
// It takes two E pulses, high nibble first, and hands the assembled byte back with a one-cycle done pulse.
//
// Ports:
//   clk      system clock (50 MHz)
//   reset    synchronous, active-high
//   start    read request, accepted only while busy=0
//   rs       register select for the request (0=status, 1=data)
//   sf_d_in  SF_D[11:8] from the pad
//   sf_d_oe  FPGA drive enable for SF_D (0 = bus released to the LCD)
//   LCD_E    enable strobe
//   LCD_RS   register select to the LCD
//   LCD_RW   1 = read
//   q        assembled byte {high nibble, low nibble}; holds until next capture or reset
//   busy     transaction in progress
//   done     one-cycle pulse, q valid in the same cycle
//   timeout  one-cycle pulse when busy-flag polling gives up (0 unless LCD_POLL_BF_EN)
//
// Optional feature macro: LCD_POLL_BF_EN. When it is defined, a status read that returns BF=1 is
// repeated, up to MAX_POLL reads in total, before done or timeout is reported.
module lcd_read #(
  parameter int unsigned T_AS     = 3,
  parameter int unsigned T_EH     = 15,
  parameter int unsigned T_SAMPLE = 10,
  parameter int unsigned T_EL     = 25,
  parameter int unsigned T_AH     = 2,
  parameter int unsigned MAX_POLL = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rs,
  input  logic [3:0] sf_d_in,
  output logic       sf_d_oe,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] q,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  if (T_SAMPLE >= T_EH) begin : g_bad_sample
    $error("lcd_read: T_SAMPLE must be smaller than T_EH");
  end
  if (MAX_POLL < 1 || MAX_POLL > 255) begin : g_bad_poll
    $error("lcd_read: MAX_POLL must fit the 8-bit poll count (1..255)");
  end

  typedef enum logic [2:0] {StIdle, StSetup, StEh1, StEl1, StEh2, StHold, StTurn} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] q_q, q_d;
  logic       e_q, e_d;
  logic       rs_q, rs_d;
  logic       rw_q, rw_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
`ifdef LCD_POLL_BF_EN
  logic [7:0] poll_q, poll_d;
  logic       timeout_q, timeout_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    q_d     = q_q;
    e_d     = e_q;
    rs_d    = rs_q;
    rw_d    = rw_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef LCD_POLL_BF_EN
    poll_d    = poll_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = 8'd0;
        if (start) begin
          // Release the bus in the same edge RW goes high so the LCD never fights the FPGA.
          rs_d    = rs;
          rw_d    = 1'b1;
          oe_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = StSetup;
`ifdef LCD_POLL_BF_EN
          poll_d  = 8'd0;
`endif
        end
      end
      StSetup: begin
        if (cnt_q == 8'(T_AS - 1)) begin
          e_d     = 1'b1;
          cnt_d   = 8'd0;
          state_d = StEh1;
        end
      end
      StEh1: begin
        if (cnt_q == 8'(T_SAMPLE)) q_d[7:4] = sf_d_in;
        if (cnt_q == 8'(T_EH - 1)) begin
          e_d     = 1'b0;
          cnt_d   = 8'd0;
          state_d = StEl1;
        end
      end
      StEl1: begin
        if (cnt_q == 8'(T_EL - 1)) begin
          e_d     = 1'b1;
          cnt_d   = 8'd0;
          state_d = StEh2;
        end
      end
      StEh2: begin
        if (cnt_q == 8'(T_SAMPLE)) q_d[3:0] = sf_d_in;
        if (cnt_q == 8'(T_EH - 1)) begin
          e_d     = 1'b0;
          cnt_d   = 8'd0;
          state_d = StHold;
        end
      end
      StHold: begin
        if (cnt_q == 8'(T_AH - 1)) begin
          cnt_d = 8'd0;
`ifdef LCD_POLL_BF_EN
          if (!rs_q && q_q[7]) begin
            if (poll_q == 8'(MAX_POLL - 1)) begin
              timeout_d = 1'b1;
              rw_d      = 1'b0;
              busy_d    = 1'b0;
              state_d   = StTurn;
            end else begin
              // LCD still busy: run another status read with RW and busy held.
              poll_d  = poll_q + 8'd1;
              state_d = StSetup;
            end
          end else begin
            rw_d    = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StTurn;
          end
`else
          rw_d    = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StTurn;
`endif
        end
      end
      StTurn: begin
        // Turnaround: RW fell last cycle, only now take the bus back.
        oe_d    = 1'b1;
        cnt_d   = 8'd0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      q_q     <= 8'h00;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      oe_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LCD_POLL_BF_EN
      poll_q    <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef LCD_POLL_BF_EN
      poll_q    <= poll_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign sf_d_oe = oe_q;
  assign LCD_E   = e_q;
  assign LCD_RS  = rs_q;
  assign LCD_RW  = rw_q;
  assign q       = q_q;
  assign busy    = busy_q;
  assign done    = done_q;
`ifdef LCD_POLL_BF_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_read.sv
// Self-checking bench for lcd_read: table of single reads with timing checks, then hand sequences
// for reset mid-transaction and (with LCD_POLL_BF_EN) busy-flag polling.
module tb_lcd_read;
`ifdef LCD_POLL_BF_EN
  localparam int unsigned MaxPoll = 4;
`else
  localparam int unsigned MaxPoll = 255;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       rs = 1'b0;
  logic [3:0] sf_d_in;
  logic       sf_d_oe, LCD_E, LCD_RS, LCD_RW, busy, done, timeout;
  logic [7:0] q;

  lcd_read #(.MAX_POLL(MaxPoll)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .rs      (rs),
    .sf_d_in (sf_d_in),
    .sf_d_oe (sf_d_oe),
    .LCD_E   (LCD_E),
    .LCD_RS  (LCD_RS),
    .LCD_RW  (LCD_RW),
    .q       (q),
    .busy    (busy),
    .done    (done),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // LCD bus model: resp[n] is the byte returned by the n-th read of the current transaction.
  logic [7:0] resp [4];
  int         e_age = 0;
  int         rd_idx = 0;
  logic       e_prev = 1'b0;
  logic       nib_sel = 1'b0;
  logic [7:0] cur_byte;
  logic [3:0] nib;

  always @(posedge clk) begin
    e_prev <= LCD_E;
    e_age  <= LCD_E ? e_age + 1 : 0;
    if (!busy) begin
      nib_sel <= 1'b0;
      rd_idx  <= 0;
    end else if (e_prev && !LCD_E) begin
      nib_sel <= ~nib_sel;
      if (nib_sel) rd_idx <= rd_idx + 1;
    end
  end

  assign cur_byte = resp[(rd_idx > 3) ? 3 : rd_idx];
  assign nib      = nib_sel ? cur_byte[3:0] : cur_byte[7:4];
  // Junk (inverted nibble) outside the data-valid window, so a mistimed capture shows up.
  assign sf_d_in  = (LCD_E && e_age >= 8) ? nib : ~nib;

  int checks = 0;
  int errors = 0;
  int total_to = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Results of the last run_txn (cycle numbers count edges after the one that accepted start).
  int   rise1, fall1, rise2, fall2, rw_fall, done_cyc, done_cnt, to_cyc, to_cnt, oe_back;
  logic rs_bad, rw_bad, oe_bad, late_busy, acc_ok, busy_evt;

  task automatic run_txn(input logic rs_v, input int inj_a, input int inj_b, input int bound);
    logic pe, prw;
    @(negedge clk);
    start = 1'b1;
    rs    = rs_v;
    @(negedge clk);
    start = 1'b0;
    rise1 = -1; fall1 = -1; rise2 = -1; fall2 = -1; rw_fall = -1;
    done_cyc = -1; done_cnt = 0; to_cyc = -1; to_cnt = 0; oe_back = -1;
    rs_bad = 0; rw_bad = 0; oe_bad = 0; late_busy = 0; busy_evt = 1'b1;
    acc_ok = busy && LCD_RW && !sf_d_oe && (LCD_RS == rs_v);
    pe = 1'b0;
    prw = 1'b1;
    for (int c = 0; c < bound; c++) begin
      if (c > 0) @(negedge clk);
      start = (c == inj_a) || (c == inj_b);
      if (LCD_E && !pe) begin
        if (rise1 < 0) rise1 = c;
        else if (rise2 < 0) rise2 = c;
      end
      if (!LCD_E && pe) begin
        if (fall1 < 0) fall1 = c;
        else if (fall2 < 0) fall2 = c;
      end
      if (!LCD_RW && prw && rw_fall < 0) rw_fall = c;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = c; busy_evt = busy; end
      end
      if (timeout) begin
        to_cnt++;
        total_to++;
        if (to_cyc < 0) begin to_cyc = c; busy_evt = busy; end
      end
      if (done_cyc < 0 && to_cyc < 0) begin
        if (LCD_RS !== rs_v) rs_bad = 1;
        if (LCD_RW !== 1'b1) rw_bad = 1;
        if (sf_d_oe !== 1'b0) oe_bad = 1;
      end
      if (sf_d_oe && oe_back < 0) oe_back = c;
      if (done_cyc >= 0 && c > done_cyc && busy) late_busy = 1;
      pe  = LCD_E;
      prw = LCD_RW;
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         inj_a;
    int         inj_b;
  } vec_t;

  vec_t vecs [4];

  initial begin
`ifdef LCD_POLL_BF_EN
    vecs[0] = '{rs: 1'b0, data: 8'h05, inj_a: -1, inj_b: -1};
`else
    vecs[0] = '{rs: 1'b0, data: 8'h85, inj_a: -1, inj_b: -1};
`endif
    vecs[1] = '{rs: 1'b1, data: 8'h41, inj_a: -1, inj_b: -1};
    vecs[2] = '{rs: 1'b1, data: 8'hA7, inj_a: 25, inj_b: 60};  // extra starts in EL1 and TURN
    vecs[3] = '{rs: 1'b0, data: 8'h3C, inj_a: -1, inj_b: -1};
    for (int i = 0; i < 4; i++) resp[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_e", LCD_E, 1'b0);
    check("rst_rw", LCD_RW, 1'b0);
    check("rst_rs", LCD_RS, 1'b0);
    check("rst_oe", sf_d_oe, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_q", q, 8'h00);
    reset = 1'b0;

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 4; i++) resp[i] = vecs[v].data;
      run_txn(vecs[v].rs, vecs[v].inj_a, vecs[v].inj_b, 70);
      check($sformatf("v%0d_accept", v), acc_ok, 1'b1);
      check($sformatf("v%0d_q", v), q, vecs[v].data);
      check($sformatf("v%0d_q_known", v), $isunknown(q), 1'b0);
      check($sformatf("v%0d_done_cyc", v), done_cyc, 60);
      check($sformatf("v%0d_done_cnt", v), done_cnt, 1);
      check($sformatf("v%0d_setup", v), rise1, 3);
      check($sformatf("v%0d_eh1", v), fall1 - rise1, 15);
      check($sformatf("v%0d_el1", v), rise2 - fall1, 25);
      check($sformatf("v%0d_eh2", v), fall2 - rise2, 15);
      check($sformatf("v%0d_hold", v), rw_fall - fall2, 2);
      check($sformatf("v%0d_rs_stable", v), rs_bad, 1'b0);
      check($sformatf("v%0d_rw_high", v), rw_bad, 1'b0);
      check($sformatf("v%0d_oe_low", v), oe_bad, 1'b0);
      check($sformatf("v%0d_oe_back", v), oe_back, 61);
      check($sformatf("v%0d_busy_at_done", v), busy_evt, 1'b0);
      check($sformatf("v%0d_no_restart", v), late_busy, 1'b0);
    end

    // Reset during EH2 (edges 43..58): reset sampled at edge 51.
    for (int i = 0; i < 4; i++) resp[i] = 8'h96;
    @(negedge clk);
    start = 1'b1;
    rs    = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    check("pre_reset_hi_nibble", q[7:4], 4'h9);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_e", LCD_E, 1'b0);
    check("mid_rst_rw", LCD_RW, 1'b0);
    check("mid_rst_oe", sf_d_oe, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_q", q, 8'h00);
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("mid_rst_no_done", done_cnt, 0);
    check("mid_rst_idle_e", LCD_E, 1'b0);

`ifdef LCD_POLL_BF_EN
    resp[0] = 8'h80; resp[1] = 8'h80; resp[2] = 8'h80; resp[3] = 8'h07;
    run_txn(1'b0, -1, -1, 260);
    check("poll_done_cyc", done_cyc, 240);
    check("poll_done_cnt", done_cnt, 1);
    check("poll_q", q, 8'h07);
    check("poll_no_timeout", to_cnt, 0);
    check("poll_rw_high", rw_bad, 1'b0);

    for (int i = 0; i < 4; i++) resp[i] = 8'h80;
    run_txn(1'b0, -1, -1, 260);
    check("stuck_timeout_cyc", to_cyc, 240);
    check("stuck_timeout_cnt", to_cnt, 1);
    check("stuck_no_done", done_cnt, 0);
    check("stuck_busy", busy_evt, 1'b0);
    check("stuck_oe_back", oe_back, 241);
    check("total_timeouts", total_to, 1);
`else
    check("total_timeouts", total_to, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
